// File: rtl/vid_fetch_sched_if.sv
// Bus master port and pixel FIFO write port of the video fetch scheduler.
interface vid_fetch_sched_if;
  logic        req_o;
  logic        gnt_i;
  logic [2:0]  cmd_o;
  logic [1:0]  len_o;
  logic [31:0] addr_o;
  logic [2:0]  cmdin_i;
  logic [31:0] datain_i;
  logic [4:0]  fifo_level_i;
  logic        fifo_wr_o;
  logic [23:0] fifo_wdata_o;

  // Scheduler side
  modport master (
    output req_o, cmd_o, len_o, addr_o, fifo_wr_o, fifo_wdata_o,
    input  gnt_i, cmdin_i, datain_i, fifo_level_i
  );

  // Bus / FIFO side
  modport slave (
    input  req_o, cmd_o, len_o, addr_o, fifo_wr_o, fifo_wdata_o,
    output gnt_i, cmdin_i, datain_i, fifo_level_i
  );
endinterface

// File: rtl/vid_fetch_sched.sv
// Video fetch scheduler: walks a frame line by line, issues 4-beat read
// bursts when the pixel FIFOs can absorb them and pushes returned RGB words.
module vid_fetch_sched #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned BURST      = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable_i,
  input  logic                     frame_start_i,
  input  logic [31:0]              base_addr_i,
  input  logic [31:0]              lineinc_i,
  input  logic [12:0]              words_per_line_i,
  input  logic [12:0]              lines_i,
  vid_fetch_sched_if.master        bus,
  output logic                     frame_done_o,
  output logic                     busy_o,
  output logic                     err_o
);

  localparam int unsigned AW  = 32;
  localparam int unsigned CW  = 13;
  localparam int unsigned BCW = 3;
  localparam int unsigned LW  = 5;
  localparam int unsigned TCW = $clog2(TIMEOUT) + 1;
  localparam logic [AW-1:0] BURST_BYTES = AW'(BURST * 4);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_BID, S_ADDR, S_DATA, S_NEXT} state_t;

  state_t          state;
  logic [AW-1:0]   line_ptr;
  logic [AW-1:0]   word_ptr;
  logic [CW-1:0]   words_left;
  logic [CW-1:0]   lines_left;
  logic [CW-1:0]   wpl_r;
  logic [BCW-1:0]  beat_cnt;
  logic [TCW-1:0]  idle_cnt;
  logic            restart_pend;
  logic            dis_pend;

  logic            beat_c;
  logic            fs_c;
  logic            zero_cfg_c;
  logic            space_c;
  logic            last_beat_c;
  logic            keep_c;
  logic            load_c;
  logic [CW-1:0]   take_c;
  logic [AW-1:0]   next_line_c;
  logic            unused_c;

  assign unused_c = ^bus.datain_i[31:24];

  // Decode of beats, FIFO space, burst completion and frame (re)load.
  always_comb begin
    beat_c      = (bus.cmdin_i == 3'b011);
    fs_c        = frame_start_i & enable_i;
    zero_cfg_c  = (words_per_line_i == '0) | (lines_i == '0);
    space_c     = (bus.fifo_level_i <= LW'(FIFO_DEPTH - BURST));
    last_beat_c = beat_c & (beat_cnt == BCW'(BURST - 1));
    take_c      = (words_left < CW'(BURST)) ? words_left : CW'(BURST);
    keep_c      = (CW'(beat_cnt) < words_left) & ~restart_pend;
    next_line_c = line_ptr + lineinc_i;
    load_c      = 1'b0;
    case (state)
      S_IDLE, S_WAIT, S_BID, S_NEXT: load_c = fs_c;
      S_DATA:  load_c = last_beat_c & enable_i & (restart_pend | frame_start_i);
      default: load_c = 1'b0;
    endcase
  end

  // Scheduler FSM with registered bus, FIFO and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      line_ptr         <= '0;
      word_ptr         <= '0;
      words_left       <= '0;
      lines_left       <= '0;
      wpl_r            <= '0;
      beat_cnt         <= '0;
      idle_cnt         <= '0;
      restart_pend     <= 1'b0;
      dis_pend         <= 1'b0;
      bus.req_o        <= 1'b0;
      bus.cmd_o        <= 3'b000;
      bus.len_o        <= 2'b00;
      bus.addr_o       <= '0;
      bus.fifo_wr_o    <= 1'b0;
      bus.fifo_wdata_o <= '0;
      frame_done_o     <= 1'b0;
      busy_o           <= 1'b0;
      err_o            <= 1'b0;
    end else begin
      bus.req_o     <= 1'b0;
      bus.cmd_o     <= 3'b000;
      bus.len_o     <= 2'b00;
      bus.addr_o    <= '0;
      bus.fifo_wr_o <= 1'b0;
      frame_done_o  <= 1'b0;

      if (state == S_DATA && beat_c) begin
        bus.fifo_wr_o    <= keep_c;
        bus.fifo_wdata_o <= bus.datain_i[23:0];
      end
      if (frame_start_i)
        err_o <= 1'b0;
      if (frame_start_i && (state == S_ADDR || state == S_DATA))
        restart_pend <= 1'b1;
      if (!enable_i && (state == S_ADDR || state == S_DATA))
        dis_pend <= 1'b1;

      if (load_c) begin
        line_ptr     <= base_addr_i;
        word_ptr     <= base_addr_i;
        words_left   <= words_per_line_i;
        lines_left   <= lines_i;
        wpl_r        <= words_per_line_i;
        restart_pend <= 1'b0;
        dis_pend     <= 1'b0;
        if (zero_cfg_c) begin
          frame_done_o <= 1'b1;
          state        <= S_IDLE;
          busy_o       <= 1'b0;
        end else begin
          state  <= S_WAIT;
          busy_o <= 1'b1;
        end
      end else begin
        case (state)
          S_IDLE: ;
          S_WAIT: begin
            if (!enable_i) begin
              state  <= S_IDLE;
              busy_o <= 1'b0;
            end else if (space_c) begin
              state     <= S_BID;
              bus.req_o <= 1'b1;
            end
          end
          S_BID: begin
            if (!enable_i) begin
              state  <= S_IDLE;
              busy_o <= 1'b0;
            end else if (bus.gnt_i) begin
              state      <= S_ADDR;
              bus.cmd_o  <= 3'b010;
              bus.len_o  <= 2'b10;
              bus.addr_o <= word_ptr;
            end else begin
              bus.req_o <= 1'b1;
            end
          end
          S_ADDR: begin
            state    <= S_DATA;
            beat_cnt <= '0;
            idle_cnt <= '0;
          end
          S_DATA: begin
            if (beat_c) begin
              idle_cnt <= '0;
              beat_cnt <= beat_cnt + BCW'(1);
              if (last_beat_c) begin
                word_ptr   <= word_ptr + BURST_BYTES;
                words_left <= words_left - take_c;
                if (dis_pend || !enable_i) begin
                  state        <= S_IDLE;
                  busy_o       <= 1'b0;
                  dis_pend     <= 1'b0;
                  restart_pend <= 1'b0;
                end else begin
                  state <= S_NEXT;
                end
              end
            end else if (idle_cnt == TCW'(TIMEOUT - 1)) begin
              err_o        <= 1'b1;
              state        <= S_IDLE;
              busy_o       <= 1'b0;
              dis_pend     <= 1'b0;
              restart_pend <= 1'b0;
            end else begin
              idle_cnt <= idle_cnt + TCW'(1);
            end
          end
          S_NEXT: begin
            if (!enable_i) begin
              state  <= S_IDLE;
              busy_o <= 1'b0;
            end else if (words_left != '0) begin
              state <= S_WAIT;
            end else begin
              lines_left <= lines_left - CW'(1);
              line_ptr   <= next_line_c;
              word_ptr   <= next_line_c;
              words_left <= wpl_r;
              if (lines_left == CW'(1)) begin
                frame_done_o <= 1'b1;
                state        <= S_IDLE;
                busy_o       <= 1'b0;
              end else begin
                state <= S_WAIT;
              end
            end
          end
          default: begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vid_fetch_sched.sv
// Self-checking bench for vid_fetch_sched: table-driven frames plus
// hand-written corner sequences, write data checked through a scoreboard.
module tb_vid_fetch_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable_i;
  logic        frame_start_i;
  logic [31:0] base_addr_i;
  logic [31:0] lineinc_i;
  logic [12:0] words_per_line_i;
  logic [12:0] lines_i;
  logic        frame_done_o;
  logic        busy_o;
  logic        err_o;

  vid_fetch_sched_if bus ();

  vid_fetch_sched #(.FIFO_DEPTH(16), .BURST(4), .TIMEOUT(64)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .enable_i         (enable_i),
    .frame_start_i    (frame_start_i),
    .base_addr_i      (base_addr_i),
    .lineinc_i        (lineinc_i),
    .words_per_line_i (words_per_line_i),
    .lines_i          (lines_i),
    .bus              (bus),
    .frame_done_o     (frame_done_o),
    .busy_o           (busy_o),
    .err_o            (err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int fd_cnt = 0;
  int wr_cnt = 0;
  int burst_cnt = 0;
  logic [23:0] exp_wq[$];
  logic [23:0] mon_exp;

  typedef struct {
    logic [31:0] base;
    logic [31:0] inc;
    int          wpl;
    int          lines;
    int          exp_writes;
    int          exp_bursts;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every FIFO push must match the oldest expected pixel.
  always @(negedge clk) begin
    if (reset_n && bus.fifo_wr_o) begin
      wr_cnt++;
      if (exp_wq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got data 0x%0h with empty queue at %0t", bus.fifo_wdata_o, $time);
      end else begin
        mon_exp = exp_wq.pop_front();
        check("fifo_wdata", 32'(bus.fifo_wdata_o), 32'(mon_exp));
      end
    end
    if (frame_done_o) fd_cnt++;
  end

  task automatic pulse_start();
    frame_start_i = 1'b1;
    @(negedge clk);
    frame_start_i = 1'b0;
  endtask

  // Grant one bid, check the address phase, then return nbeats data beats.
  task automatic serve_burst(input logic [31:0] exp_addr, input int nvalid, input int nbeats,
                             input int kill_at, input logic [31:0] new_base);
    int t;
    logic [31:0] d;
    t = 0;
    while (!bus.req_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("req_o_bid", 32'(bus.req_o), 32'd1);
    if (t >= 200) return;
    bus.gnt_i = 1'b1;
    @(negedge clk);
    bus.gnt_i = 1'b0;
    check("cmd_o", 32'(bus.cmd_o), 32'd2);
    check("len_o", 32'(bus.len_o), 32'd2);
    check("addr_o", bus.addr_o, exp_addr);
    burst_cnt++;
    @(negedge clk);
    for (int i = 0; i < nbeats; i++) begin
      d = $urandom;
      bus.cmdin_i  = 3'b011;
      bus.datain_i = d;
      if (i < nvalid && i <= kill_at) exp_wq.push_back(d[23:0]);
      if (i == kill_at) begin
        frame_start_i = 1'b1;
        base_addr_i   = new_base;
      end
      @(negedge clk);
      frame_start_i = 1'b0;
      bus.cmdin_i   = 3'b000;
      bus.datain_i  = $urandom;
      if (i < nbeats - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic wait_done(input int fd0);
    int t;
    t = 0;
    while (fd_cnt == fd0 && t < 30) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic run_frame(input logic [31:0] base, input logic [31:0] inc, input int wpl, input int lines);
    int nb;
    int nv;
    base_addr_i      = base;
    lineinc_i        = inc;
    words_per_line_i = 13'(wpl);
    lines_i          = 13'(lines);
    pulse_start();
    nb = (wpl + 3) / 4;
    for (int l = 0; l < lines; l++) begin
      for (int b = 0; b < nb; b++) begin
        nv = (wpl - 4 * b < 4) ? wpl - 4 * b : 4;
        serve_burst(base + 32'(l) * inc + 32'(16 * b), nv, 4, 99, 32'd0);
      end
    end
  endtask

  initial begin
    int fd0;
    int w0;
    int b0;
    int t;

    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int fd0;
    int w0;
    int b0;
    int t;

    vecs[0] = '{32'h0000_1000, 32'h0000_0100, 8, 2, 16, 4};
    vecs[1] = '{32'h0000_1000, 32'h0000_0100, 6, 1, 6, 2};
    vecs[2] = '{32'hFFFF_FFF0, 32'h0000_0020, 5, 2, 10, 4};
    vecs[3] = '{32'h0000_2000, 32'h0000_0040, 4, 3, 12, 3};
    vecs[4] = '{32'h0000_3000, 32'h0000_0100, 0, 3, 0, 0};
    vecs[5] = '{32'h0000_4000, 32'h0000_0100, 3, 0, 0, 0};

    reset_n          = 1'b0;
    enable_i         = 1'b1;
    frame_start_i    = 1'b0;
    base_addr_i      = '0;
    lineinc_i        = '0;
    words_per_line_i = '0;
    lines_i          = '0;
    bus.gnt_i        = 1'b0;
    bus.cmdin_i      = 3'b000;
    bus.datain_i     = '0;
    bus.fifo_level_i = 5'd0;
    repeat (3) @(negedge clk);
    check("reset_req_o", 32'(bus.req_o), 32'd0);
    check("reset_busy_o", 32'(busy_o), 32'd0);
    check("reset_err_o", 32'(err_o), 32'd0);
    check("reset_fifo_wr_o", 32'(bus.fifo_wr_o), 32'd0);
    check("reset_cmd_o", 32'(bus.cmd_o), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      fd0 = fd_cnt;
      w0  = wr_cnt;
      b0  = burst_cnt;
      run_frame(vecs[v].base, vecs[v].inc, vecs[v].wpl, vecs[v].lines);
      wait_done(fd0);
      @(negedge clk);
      check($sformatf("v%0d_frame_done", v), 32'(fd_cnt - fd0), 32'd1);
      check($sformatf("v%0d_writes", v), 32'(wr_cnt - w0), 32'(vecs[v].exp_writes));
      check($sformatf("v%0d_bursts", v), 32'(burst_cnt - b0), 32'(vecs[v].exp_bursts));
      check($sformatf("v%0d_queue_empty", v), 32'(exp_wq.size()), 32'd0);
      check($sformatf("v%0d_busy_o", v), 32'(busy_o), 32'd0);
      check($sformatf("v%0d_err_o", v), 32'(err_o), 32'd0);
    end

    // Latency: frame_start -> req_o two cycles later
    fd0 = fd_cnt;
    base_addr_i = 32'h0000_9000; words_per_line_i = 13'd4; lines_i = 13'd1;
    pulse_start();
    check("lat_req_1cyc", 32'(bus.req_o), 32'd0);
    check("lat_busy", 32'(busy_o), 32'd1);
    @(negedge clk);
    check("lat_req_2cyc", 32'(bus.req_o), 32'd1);
    serve_burst(32'h0000_9000, 4, 4, 99, 32'd0);
    wait_done(fd0);
    check("lat_frame_done", 32'(fd_cnt - fd0), 32'd1);

    // FIFO level threshold
    fd0 = fd_cnt;
    bus.fifo_level_i = 5'd13;
    base_addr_i = 32'h0000_8000;
    pulse_start();
    repeat (5) @(negedge clk);
    check("lvl13_req_o", 32'(bus.req_o), 32'd0);
    check("lvl13_busy_o", 32'(busy_o), 32'd1);
    bus.fifo_level_i = 5'd12;
    @(negedge clk);
    check("lvl12_req_o", 32'(bus.req_o), 32'd1);
    bus.fifo_level_i = 5'd0;
    serve_burst(32'h0000_8000, 4, 4, 99, 32'd0);
    wait_done(fd0);
    check("lvl_frame_done", 32'(fd_cnt - fd0), 32'd1);

    // Enable drop while waiting for FIFO space
    bus.fifo_level_i = 5'd16;
    pulse_start();
    repeat (2) @(negedge clk);
    enable_i = 1'b0;
    @(negedge clk);
    check("dis_busy_o", 32'(busy_o), 32'd0);
    check("dis_req_o", 32'(bus.req_o), 32'd0);
    enable_i = 1'b1;
    bus.fifo_level_i = 5'd0;
    repeat (3) @(negedge clk);
    check("dis_stays_idle", 32'(bus.req_o), 32'd0);

    // Data-phase timeout
    fd0 = fd_cnt;
    base_addr_i = 32'h0000_A000; words_per_line_i = 13'd4; lines_i = 13'd1;
    pulse_start();
    serve_burst(32'h0000_A000, 0, 0, 99, 32'd0);
    t = 0;
    while (!err_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("to_err_o", 32'(err_o), 32'd1);
    check("to_busy_o", 32'(busy_o), 32'd0);
    check("to_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
    words_per_line_i = 13'd0;
    pulse_start();
    check("to_err_cleared", 32'(err_o), 32'd0);
    @(negedge clk);

    // Restart during beat 2: beats 3,4 dropped, next burst from the new base
    fd0 = fd_cnt;
    w0  = wr_cnt;
    base_addr_i = 32'h0000_1000; words_per_line_i = 13'd8; lines_i = 13'd1;
    pulse_start();
    serve_burst(32'h0000_1000, 4, 4, 1, 32'h0000_5000);
    serve_burst(32'h0000_5000, 4, 4, 99, 32'd0);
    serve_burst(32'h0000_5010, 4, 4, 99, 32'd0);
    wait_done(fd0);
    @(negedge clk);
    check("rs_frame_done", 32'(fd_cnt - fd0), 32'd1);
    check("rs_writes", 32'(wr_cnt - w0), 32'd10);
    check("rs_queue_empty", 32'(exp_wq.size()), 32'd0);

    // Reset asserted mid-DATA
    base_addr_i = 32'h0000_B000; words_per_line_i = 13'd4; lines_i = 13'd1;
    pulse_start();
    serve_burst(32'h0000_B000, 1, 1, 99, 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_fifo_wr_o", 32'(bus.fifo_wr_o), 32'd0);
    check("rst_fifo_wdata_o", 32'(bus.fifo_wdata_o), 32'd0);
    check("rst_busy_o", 32'(busy_o), 32'd0);
    check("rst_req_o", 32'(bus.req_o), 32'd0);
    check("rst_addr_o", bus.addr_o, 32'd0);
    check("rst_frame_done_o", 32'(frame_done_o), 32'd0);
    exp_wq.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_no_req", 32'(bus.req_o), 32'd0);
    check("rst_idle", 32'(busy_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
